// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte/halfword/word load-store sequencer between a core and a
//   word-organised memory with per-lane byte enables.
//
//   Core side : clk, rst (sync, active-high), req, is_store, funct3[2:0],
//               addr[31:0], wdata[31:0] -> busy, done, rdata[31:0], err
//   Memory    : mem_cs (active-low), mem_wr (0 = write), mem_mask[3:0],
//               mem_addr[31:0] (word index), mem_wdata[31:0] <- mem_rdata[31:0]
//
//   Optional feature macro: LSU_MISALIGN_SPLIT_EN
//     defined   : word-crossing accesses are split into two memory cycles
//     undefined : word-crossing accesses complete with err=1, no memory access
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t      state, state_nxt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q;
  logic [31:0] word0_q;
  logic [23:0] word1_q;   // a split load never needs the top byte of the second word

  logic        cs_nxt, wr_nxt;
  logic [3:0]  mask_nxt;
  logic [31:0] maddr_nxt, mwd_nxt;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic st, input logic [2:0] f3);
    if (st)
      return (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    logic signed [31:0] ext;
    case (f3)
      3'b000:  ext = 32'($signed(raw[7:0]));
      3'b001:  ext = 32'($signed(raw[15:0]));
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  // Lane footprint of the incoming request over two words: [3:0] first word,
  // [7:4] spill-over into the next word (non-zero means the access crosses).
  logic [7:0] lanes_in;
  logic       cross_in, accept_ok;
  assign lanes_in = {4'b0000, size_mask(funct3[1:0])} << addr[1:0];
  assign cross_in = |lanes_in[7:4];
`ifdef LSU_MISALIGN_SPLIT_EN
  assign accept_ok = !illegal_f3(is_store, funct3);
`else
  assign accept_ok = !illegal_f3(is_store, funct3) && !cross_in;
`endif

  // Lanes of the latched access that fall into the second word.
  logic [3:0] hi_q;
  assign hi_q = size_mask(f3_q[1:0]) >> (3'd4 - {1'b0, addr_q[1:0]});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = accept_ok ? ACC1 : DONE;
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: state_nxt = (|hi_q) ? ACC2 : DONE;
`else
      ACC1: state_nxt = DONE;
`endif
      ACC2: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  logic [31:0] raw;
  always_comb begin
    case (addr_q[1:0])
      2'd0: raw = word0_q;
      2'd1: raw = {word1_q[7:0],  word0_q[31:8]};
      2'd2: raw = {word1_q[15:0], word0_q[31:16]};
      default: raw = {word1_q[23:0], word0_q[31:24]};
    endcase
    busy  = (state != IDLE);
    done  = (state == DONE);
    err   = done && err_q;
    rdata = (done && !err_q && !st_q) ? extend_load(f3_q, raw) : 32'd0;
  end

  // Request latch and load capture
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      word0_q <= 32'd0;
      word1_q <= 24'd0;
    end else begin
      if (state == IDLE && req) begin
        st_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= !accept_ok;
      end
      if (state == ACC1 && !st_q) word0_q <= mem_rdata;
      if (state == ACC2 && !st_q) word1_q <= mem_rdata[23:0];
    end
  end

  // Memory-side values for the coming cycle; registered so they stay
  // stable across the memory's falling-edge write.
  always_comb begin
    cs_nxt    = 1'b1;
    wr_nxt    = 1'b1;
    mask_nxt  = 4'b0000;
    maddr_nxt = 32'd0;
    mwd_nxt   = 32'd0;
    if (state_nxt == ACC1) begin
      cs_nxt    = 1'b0;
      wr_nxt    = !is_store;
      maddr_nxt = {2'b00, addr[31:2]};
      if (is_store) begin
        mask_nxt = lanes_in[3:0];
        mwd_nxt  = wdata << {addr[1:0], 3'b000};
      end
    end else if (state_nxt == ACC2) begin
      cs_nxt    = 1'b0;
      wr_nxt    = !st_q;
      maddr_nxt = {2'b00, addr_q[31:2] + 30'd1};   // 30-bit add wraps to 0
      if (st_q) begin
        mask_nxt = hi_q;
        mwd_nxt  = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs    <= 1'b1;
      mem_wr    <= 1'b1;
      mem_mask  <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      mem_cs    <= cs_nxt;
      mem_wr    <= wr_nxt;
      mem_mask  <= mask_nxt;
      mem_addr  <= maddr_nxt;
      mem_wdata <= mwd_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_cs, mem_wr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err(err), .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory, 256 words, falling-edge write, combinational read.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(negedge clk) begin
    if (!mem_cs && !mem_wr)
      for (int i = 0; i < 4; i++)
        if (mem_mask[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observations from one transaction
  int          r_nacc, r_ndone, r_lat;
  logic        r_err, r_busy_after, r_a1wr;
  logic [31:0] r_rdata, r_a1addr, r_a1wd, r_a2addr, r_a2wd;
  logic [3:0]  r_a1mask, r_a2mask;

  task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold);
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    r_nacc = 0; r_ndone = 0; r_lat = -1; r_err = 1'b0; r_rdata = 32'd0;
    r_busy_after = 1'b1; r_a1wr = 1'b0;
    r_a1addr = 0; r_a1wd = 0; r_a1mask = 0; r_a2addr = 0; r_a2wd = 0; r_a2mask = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!mem_cs) begin
        if (r_nacc == 0) begin
          r_a1addr = mem_addr; r_a1mask = mem_mask; r_a1wd = mem_wdata; r_a1wr = mem_wr;
        end else begin
          r_a2addr = mem_addr; r_a2mask = mem_mask; r_a2wd = mem_wdata;
        end
        r_nacc++;
      end
      if (done) begin
        if (r_ndone == 0) begin
          r_lat = k; r_err = err; r_rdata = rdata;
        end
        r_ndone++;
      end else if (r_ndone == 1 && k == r_lat + 1) begin
        r_busy_after = busy;
      end
      if (k >= hold) req = 1'b0;
    end
  endtask

  int n_cs;

  initial begin
    rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cs", mem_cs, 1);
    chk("rst_wr", mem_wr, 1);
    chk("rst_mask", mem_mask, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // SB 0x105 <- 0xAB
    xact(1'b1, 3'b000, 32'h105, 32'h0000_00AB, 0);
    chk("sb_nacc", r_nacc, 1);
    chk("sb_addr", r_a1addr, 32'h41);
    chk("sb_mask", r_a1mask, 4'b0010);
    chk("sb_wdata", r_a1wd, 32'h0000_AB00);
    chk("sb_wr", r_a1wr, 0);
    chk("sb_lat", r_lat, 1);
    chk("sb_err", r_err, 0);
    chk("sb_rdata", r_rdata, 0);
    chk("sb_busy_after", r_busy_after, 0);

    // LB / LBU 0x105
    xact(1'b0, 3'b000, 32'h105, 32'd0, 0);
    chk("lb_rdata", r_rdata, 32'hFFFF_FFAB);
    chk("lb_mask", r_a1mask, 4'b0000);
    chk("lb_wr", r_a1wr, 1);
    chk("lb_lat", r_lat, 1);
    xact(1'b0, 3'b100, 32'h105, 32'd0, 0);
    chk("lbu_rdata", r_rdata, 32'h0000_00AB);

    // SH 0x102 <- 0xBEEF, then LH / LHU
    xact(1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 0);
    chk("sh_addr", r_a1addr, 32'h40);
    chk("sh_mask", r_a1mask, 4'b1100);
    chk("sh_wdata", r_a1wd, 32'hBEEF_0000);
    xact(1'b0, 3'b001, 32'h102, 32'd0, 0);
    chk("lh_rdata", r_rdata, 32'hFFFF_BEEF);
    xact(1'b0, 3'b101, 32'h102, 32'd0, 0);
    chk("lhu_rdata", r_rdata, 32'h0000_BEEF);

    // Aligned SW / LW 0x108; LW repeated with req held while busy
    xact(1'b1, 3'b010, 32'h108, 32'h1122_3344, 0);
    chk("sw_mask", r_a1mask, 4'b1111);
    chk("sw_addr", r_a1addr, 32'h42);
    xact(1'b0, 3'b010, 32'h108, 32'd0, 1);
    chk("lw_rdata", r_rdata, 32'h1122_3344);
    chk("lw_hold_ndone", r_ndone, 1);

    // Illegal accesses
    xact(1'b0, 3'b011, 32'h100, 32'd0, 1);
    chk("ill_ld_err", r_err, 1);
    chk("ill_ld_nacc", r_nacc, 0);
    chk("ill_ld_rdata", r_rdata, 0);
    chk("ill_ld_ndone", r_ndone, 1);
    xact(1'b1, 3'b100, 32'h100, 32'hFF, 0);
    chk("ill_st_err", r_err, 1);
    chk("ill_st_nacc", r_nacc, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Split SW 0x103 then LW 0x103
    xact(1'b1, 3'b010, 32'h103, 32'h1122_3344, 0);
    chk("ssw_nacc", r_nacc, 2);
    chk("ssw_a1addr", r_a1addr, 32'h40);
    chk("ssw_a1mask", r_a1mask, 4'b1000);
    chk("ssw_a1wd", r_a1wd, 32'h4400_0000);
    chk("ssw_a2addr", r_a2addr, 32'h41);
    chk("ssw_a2mask", r_a2mask, 4'b0111);
    chk("ssw_a2wd", r_a2wd, 32'h0011_2233);
    chk("ssw_lat", r_lat, 2);
    xact(1'b0, 3'b010, 32'h103, 32'd0, 0);
    chk("slw_rdata", r_rdata, 32'h1122_3344);
    chk("slw_err", r_err, 0);

    // Word-index wrap on a split LHU at 0xFFFFFFFF
    xact(1'b1, 3'b010, 32'h3FC, 32'h8000_0000, 0);
    xact(1'b1, 3'b010, 32'h000, 32'h0000_00C1, 0);
    xact(1'b0, 3'b101, 32'hFFFF_FFFF, 32'd0, 0);
    chk("wrap_a1addr", r_a1addr, 32'h3FFF_FFFF);
    chk("wrap_a2addr", r_a2addr, 32'h0);
    chk("wrap_rdata", r_rdata, 32'h0000_C180);

    // Reset during ACC1 of a split SW
    xact(1'b1, 3'b010, 32'h204, 32'h5A5A_5A5A, 0);
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h203; wdata = 32'hAABB_CCDD;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rsta_acc1_cs", mem_cs, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rsta_busy", busy, 0);
    chk("rsta_cs", mem_cs, 1);
    chk("rsta_done", done, 0);
    n_cs = 0;
    repeat (4) begin
      @(negedge clk);
      if (!mem_cs) n_cs++;
    end
    chk("rsta_no_acc2", n_cs, 0);
    xact(1'b0, 3'b010, 32'h204, 32'd0, 0);
    chk("rsta_word_kept", r_rdata, 32'h5A5A_5A5A);
`else
    // Crossing accesses rejected
    xact(1'b0, 3'b001, 32'h7, 32'd0, 0);
    chk("xlh_err", r_err, 1);
    chk("xlh_nacc", r_nacc, 0);
    chk("xlh_rdata", r_rdata, 0);
    xact(1'b1, 3'b010, 32'h103, 32'h1122_3344, 0);
    chk("xsw_err", r_err, 1);
    chk("xsw_nacc", r_nacc, 0);
    // memory at word 0x40 still holds the earlier SH data
    xact(1'b0, 3'b010, 32'h100, 32'd0, 0);
    chk("xsw_mem_kept", r_rdata[31:16], 16'hBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge domain); rst input 1 (synchronous, active-high).
REQ-002 SHALL provide these core-side ports:
- req input 1: access request, sampled only in IDLE.
- is_store input 1: 1 = store, 0 = load.
- funct3 input 3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- addr input 32: byte address.
- wdata input 32: store data, right-justified.
REQ-003 SHALL provide these core-side outputs:
- busy output 1: high whenever state is not IDLE.
- done output 1: one-cycle completion pulse.
- rdata output 32: extended load result, valid only while done is high.
- err output 1: illegal funct3 or disallowed misalignment, valid only while done is high.
REQ-004 SHALL provide these memory-side ports:
- mem_cs output 1: active-low chip select.
- mem_wr output 1: 0 = write, 1 = read.
- mem_mask output 4: byte-lane enables.
- mem_addr output 32: word index.
- mem_wdata output 32: lane-aligned store data.
- mem_rdata input 32: combinational read data.

Function
REQ-005 SHALL implement FSM states IDLE, ACC1, ACC2, DONE.
REQ-006 IDLE transitions:
- req=1 with legal access: go to ACC1.
- req=1 with illegal access: go to DONE with err=1 and no memory access.
- req=0: stay in IDLE.
REQ-007 SHALL latch is_store, funct3, addr and wdata on the accepting edge; req SHALL be ignored while busy=1.
REQ-008 ACC1 SHALL go to ACC2 if the access crosses a word boundary, else to DONE. ACC2 SHALL always go to DONE. DONE SHALL always go to IDLE.
REQ-009 An access SHALL cross a word boundary when halfword offset=3 or word offset≠0.
REQ-010 Memory outputs SHALL be registered and constant for the whole ACC cycle, so the memory's falling-edge write sees stable values.
REQ-011 Outside ACC1/ACC2, memory outputs SHALL be idle: mem_cs=1, mem_wr=1, mem_mask=0000, mem_wdata=0.
REQ-012 In ACC1: mem_addr={2'b00,addr[31:2]}, mem_mask=(size mask << addr[1:0]) truncated to 4 bits, mem_wdata=wdata << 8*addr[1:0]. Size masks: B=0001, H=0011, W=1111.
REQ-013 In ACC2: mem_addr=ACC1 word index+1, with wrap from 0x3FFFFFFF to 0. mem_mask holds the remaining lanes starting at lane 0. mem_wdata=wdata >> (32-8*addr[1:0]).
REQ-014 Loads SHALL drive mem_wr=1 and mem_mask=0000, and SHALL capture mem_rdata on the rising edge ending each ACC cycle.
REQ-015 Load result: select bytes from the captured word(s) starting at offset addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. rdata SHALL be 0 for stores and for err.
REQ-016 Latency: request accepted at edge N gives done in cycle N+2 (aligned) or N+3 (split). busy SHALL drop in the cycle after done.
REQ-017 Illegal funct3: any store funct3 other than 000/001/010, and load funct3 011/110/111.

Reset
REQ-018 rst=1 at a rising edge SHALL force state to IDLE and clear busy, done, err, rdata, all captured data and the latched request.
REQ-019 After reset, memory outputs SHALL be idle as defined in REQ-011.
REQ-020 Reset during ACC1 or ACC2 SHALL abort the access. Any write already committed at the preceding falling edge remains; no ACC2 access is issued.

Configuration
REQ-021 Macro LSU_MISALIGN_SPLIT_EN behaviour:
- Defined: crossing accesses are split per REQ-008 to REQ-013.
- Undefined: crossing accesses go IDLE to DONE with err=1, rdata=0, no memory access, and ACC2 is unreachable.

Verification
REQ-022 Store then load:
- SB addr=0x105, wdata=0xAB gives one ACC with mem_addr=0x41, mask=0010, mem_wdata=0x0000AB00.
- A following LB gives rdata=0xFFFFFFAB; LBU gives 0x000000AB.
REQ-023 With the macro on, SW addr=0x103, wdata=0x11223344 gives:
- ACC1: mem_addr=0x40, mask=1000, mem_wdata=0x44000000.
- ACC2: mem_addr=0x41, mask=0111, mem_wdata=0x00112233.
- done in cycle N+3.
- A following LW 0x103 returns 0x11223344.
REQ-024 With the macro off, LH addr=0x7 gives done with err=1, mem_cs=1 throughout and rdata=0.
REQ-025 Load funct3=011 gives err=1 and no memory access. req pulsed while busy=1 is ignored, with exactly one done.
REQ-026 rst asserted during ACC1 of a split SW gives IDLE next cycle, no ACC2 access, the word at index+1 unchanged, and busy=0.
